mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports, clock and reset first (name  direction  width  meaning):
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 bus_in  in  16  value currently driven on the shared datapath bus.
REQ-005 ld_mar  in  1  load MAR from bus_in.
REQ-006 ld_mdr  in  1  load MDR from bus_in.
REQ-007 mio_en  in  1  start a memory access.
REQ-008 r_w  in  1  access type: 1 write, 0 read; sampled with mio_en.
REQ-009 data_size  in  1  access size: 1 word, 0 byte; sampled with ld_mdr and with mio_en.
REQ-010 mdr_out  out  16  MDR contents; goes to the external tri-state bus gate.
REQ-011 mem_addr  out  16  equals MAR.
REQ-012 mem_wdata  out  16  equals MDR.
REQ-013 mem_en  out  1  high exactly while state is ACCESS.
REQ-014 mem_we  out  2  byte write enables, [1] high byte, [0] low byte; nonzero only in ACCESS for writes.
REQ-015 mem_rdata  in  16  memory read data; valid when mem_ready=1.
REQ-016 mem_ready  in  1  memory completion strobe.
REQ-017 r  out  1  access-complete pulse to the control FSM.
REQ-018 err  out  1  timeout pulse (see Configuration).

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; transitions are IDLE->ACCESS on mio_en, ACCESS->DONE on mem_ready, DONE->IDLE unconditionally.
REQ-020 In IDLE, ld_mar=1 SHALL set MAR<=bus_in; ld_mar outside IDLE SHALL be ignored.
REQ-021 In IDLE, ld_mdr=1 SHALL set MDR<=bus_in for word size, or MDR<={bus_in[7:0],bus_in[7:0]} for byte size; ld_mdr outside IDLE SHALL be ignored.
REQ-022 If ld_mar or ld_mdr coincides with mio_en in IDLE, the access SHALL use the newly loaded MAR/MDR values.
REQ-023 mio_en outside IDLE SHALL be ignored; r_w and data_size SHALL be latched at access start and held through ACCESS.
REQ-024 Word write: mem_we=2'b11. Byte write: mem_we=2'b01 if MAR[0]=0, 2'b10 if MAR[0]=1.
REQ-025 Word read: on mem_ready, MDR<=mem_rdata.
REQ-026 Byte read: on mem_ready, MDR<=sign-extended byte 16'(mem_rdata[7:0]) if MAR[0]=0, or 16'(mem_rdata[15:8]) if MAR[0]=1.
REQ-027 Latency: mio_en sampled at edge 0 -> ACCESS from edge 0; mem_ready sampled high at edge k -> MDR updated and DONE at edge k; r=1 for exactly one cycle (state DONE); IDLE at edge k+1.
REQ-028 mem_ready SHALL be ignored in IDLE and DONE; minimum access is mem_ready high in the first ACCESS cycle, giving r two cycles after mio_en.
REQ-029 Writes SHALL NOT modify MDR.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, MAR=0, MDR=0, mem_en=0, mem_we=0, r=0, err=0, timeout counter=0.
REQ-031 Reset asserted mid-access SHALL abort the access, with no r and no MDR update; after release the block SHALL be in IDLE.

Configuration
REQ-032 Macro MEM_TIMEOUT_EN defined: a 4-bit counter SHALL run in ACCESS, cleared on entry. If 16 ACCESS cycles elapse without mem_ready, the block SHALL go to IDLE, pulse err for one cycle, leave MDR unchanged, and not assert r. mem_ready in the 16th cycle SHALL win over the timeout.
REQ-033 Macro MEM_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely, no counter logic SHALL exist, and err SHALL be tied to 0.

Verification
REQ-034 ld_mar with bus_in=0x3000, then ld_mdr word 0xBEEF, then mio_en write word, mem_ready after 3 cycles -> mem_addr=0x3000, mem_we=11, mem_wdata=0xBEEF, one r pulse.
REQ-035 MAR=0x3001, byte read, mem_rdata=0x8012 -> mdr_out=0xFF80; repeat with MAR=0x3000 -> mdr_out=0x0012.
REQ-036 ld_mdr byte with bus_in=0x1234, MAR=0x4001, write -> mem_wdata=0x3434, mem_we=10.
REQ-037 mio_en, ld_mar and ld_mdr pulsed during ACCESS -> ignored; MAR, MDR and the transaction are unchanged.
REQ-038 rst_n dropped in the 2nd ACCESS cycle -> all outputs 0 immediately, no r pulse.
REQ-039 With MEM_TIMEOUT_EN and mem_ready held at 0 -> err pulses once after 16 ACCESS cycles, MDR unchanged, r stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers plus an IDLE/ACCESS/DONE handshake FSM toward memory.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  output logic [15:0] mdr_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        r,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = 4;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] mar, mar_d;
  logic [DW-1:0] mdr, mdr_d;
  logic          wr_q, wr_d;
  logic          word_q, word_d;
  logic          en_d, r_d;
  logic [1:0]    we_d;
  logic [BW-1:0] rd_byte;

`ifdef MEM_TIMEOUT_EN
  logic [TW-1:0] cnt, cnt_d;
  logic          err_q, err_d;
`endif

  // Byte lane selected by the address LSB for byte reads
  assign rd_byte = mar[0] ? mem_rdata[15:8] : mem_rdata[7:0];

  // Next-state, register updates and registered output values
  always_comb begin
    state_d = state;
    mar_d   = mar;
    mdr_d   = mdr;
    wr_d    = wr_q;
    word_d  = word_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt;
    err_d   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr) mdr_d = data_size ? bus_in : {bus_in[7:0], bus_in[7:0]};
        if (mio_en) begin
          state_d = ACCESS;
          wr_d    = r_w;
          word_d  = data_size;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!wr_q) mdr_d = word_q ? mem_rdata : {{BW{rd_byte[BW-1]}}, rd_byte};
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == {TW{1'b1}}) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + TW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs track the state being entered so they line up with the state register
    en_d = (state_d == ACCESS);
    r_d  = (state_d == DONE);
    we_d = 2'b00;
    if (state_d == ACCESS && wr_d) begin
      if (word_d)       we_d = 2'b11;
      else if (mar_d[0]) we_d = 2'b10;
      else               we_d = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      wr_q   <= 1'b0;
      word_q <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 2'b00;
      r      <= 1'b0;
    end else begin
      state  <= state_d;
      mar    <= mar_d;
      mdr    <= mdr_d;
      wr_q   <= wr_d;
      word_q <= word_d;
      mem_en <= en_d;
      mem_we <= we_d;
      r      <= r_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter and one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mdr_out   = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of full transactions plus
// hand-written sequences for coincident loads, ignored inputs, reset abort and timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
  logic [15:0] mdr_out, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_ready, r, err;
  logic [1:0]  mem_we;

  int n_pass = 0;
  int n_chk  = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .data_size(data_size), .mdr_out(mdr_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .r(r), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic        mdr_word;
    logic        wr;
    logic        word;
    int          dly;
    logic [15:0] rdata;
    logic [1:0]  we;
    logic [15:0] wdata;
    logic [15:0] mdr_after;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] mar_v, input logic [15:0] mdr_v, input logic word);
    bus_in = mar_v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
    bus_in = mdr_v; ld_mdr = 1'b1; data_size = word;
    tick();
    ld_mdr = 1'b0;
  endtask

  task automatic start(input logic wr, input logic word);
    mio_en = 1'b1; r_w = wr; data_size = word;
    tick();
    mio_en = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    load(v.mar, v.mdr_in, v.mdr_word);
    start(v.wr, v.word);
    chk($sformatf("v%0d mem_en", i), 16'(mem_en), 16'h1);
    chk($sformatf("v%0d mem_we", i), 16'(mem_we), 16'(v.we));
    chk($sformatf("v%0d mem_addr", i), mem_addr, v.mar);
    chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
    for (int k = 0; k < v.dly; k++) tick();
    mem_ready = 1'b1; mem_rdata = v.rdata;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0;
    chk($sformatf("v%0d r", i), 16'(r), 16'h1);
    chk($sformatf("v%0d mdr_out", i), mdr_out, v.mdr_after);
    tick();
    chk($sformatf("v%0d r_after", i), 16'(r), 16'h0);
    chk($sformatf("v%0d en_after", i), 16'(mem_en), 16'h0);
  endtask

  initial begin
    //           mar       mdr_in   mw   wr    wd   dly rdata     we     wdata     mdr_after
    vecs[0] = '{16'h3000, 16'hBEEF, 1'b1, 1'b1, 1'b1, 3, 16'h0000, 2'b11, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{16'h3001, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h8012, 2'b00, 16'h0000, 16'hFF80};
    vecs[2] = '{16'h3000, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 16'h8012, 2'b00, 16'h0000, 16'h0012};
    vecs[3] = '{16'h4001, 16'h1234, 1'b0, 1'b1, 1'b0, 1, 16'h0000, 2'b10, 16'h3434, 16'h3434};
    vecs[4] = '{16'h1000, 16'h5555, 1'b1, 1'b0, 1'b1, 0, 16'hA5C3, 2'b00, 16'h5555, 16'hA5C3};
    vecs[5] = '{16'h2002, 16'h00AB, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 2'b01, 16'hABAB, 16'hABAB};
    vecs[6] = '{16'h2003, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h7F00, 2'b00, 16'h0000, 16'h007F};
    vecs[7] = '{16'h2004, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 16'h00FE, 2'b00, 16'h0000, 16'hFFFE};

    rst_n = 1'b0; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; data_size = 0;
    mem_rdata = '0; mem_ready = 0;
    tick(); tick();
    chk("rst mem_en", 16'(mem_en), 16'h0);
    chk("rst mem_we", 16'(mem_we), 16'h0);
    chk("rst r", 16'(r), 16'h0);
    chk("rst err", 16'(err), 16'h0);
    chk("rst mar", mem_addr, 16'h0);
    chk("rst mdr", mdr_out, 16'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Loads coinciding with mio_en: access uses the new MAR/MDR
    bus_in = 16'h5001; ld_mar = 1'b1; ld_mdr = 1'b1;
    start(1'b1, 1'b0);
    ld_mar = 1'b0; ld_mdr = 1'b0;
    chk("coin mem_addr", mem_addr, 16'h5001);
    chk("coin mem_wdata", mem_wdata, 16'h0101);
    chk("coin mem_we", 16'(mem_we), 16'h2);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    chk("coin r", 16'(r), 16'h1);
    chk("coin mdr", mdr_out, 16'h0101);
    tick();

    // Loads and mio_en during ACCESS are ignored
    load(16'h7000, 16'h2222, 1'b1);
    start(1'b0, 1'b1);
    bus_in = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1; r_w = 1'b1; data_size = 1'b0;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    chk("ign mem_addr", mem_addr, 16'h7000);
    chk("ign mem_wdata", mem_wdata, 16'h2222);
    chk("ign mem_we", 16'(mem_we), 16'h0);
    mem_ready = 1'b1; mem_rdata = 16'h9999; tick(); mem_ready = 1'b0;
    chk("ign r", 16'(r), 16'h1);
    chk("ign mdr", mdr_out, 16'h9999);
    tick();
    tick();
    chk("ign no requeue", 16'(mem_en), 16'h0);
    mem_ready = 1'b1; mem_rdata = 16'h1111; tick(); mem_ready = 1'b0;
    chk("idle ready r", 16'(r), 16'h0);
    chk("idle ready mdr", mdr_out, 16'h9999);

`ifdef MEM_TIMEOUT_EN
    // 16 ACCESS cycles without mem_ready -> one err pulse, MDR kept
    start(1'b0, 1'b1);
    for (int k = 0; k < 15; k++) tick();
    chk("to cyc16 en", 16'(mem_en), 16'h1);
    chk("to cyc16 err", 16'(err), 16'h0);
    tick();
    chk("to err", 16'(err), 16'h1);
    chk("to en", 16'(mem_en), 16'h0);
    chk("to r", 16'(r), 16'h0);
    chk("to mdr", mdr_out, 16'h9999);
    tick();
    chk("to err clr", 16'(err), 16'h0);
    // mem_ready in the 16th cycle wins
    start(1'b0, 1'b1);
    for (int k = 0; k < 15; k++) tick();
    mem_ready = 1'b1; mem_rdata = 16'h4321; tick(); mem_ready = 1'b0;
    chk("to win r", 16'(r), 16'h1);
    chk("to win err", 16'(err), 16'h0);
    chk("to win mdr", mdr_out, 16'h4321);
    tick();
`else
    // Without timeout, ACCESS waits indefinitely
    start(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) tick();
    chk("wait en", 16'(mem_en), 16'h1);
    chk("wait err", 16'(err), 16'h0);
    mem_ready = 1'b1; mem_rdata = 16'h4321; tick(); mem_ready = 1'b0;
    chk("wait r", 16'(r), 16'h1);
    chk("wait mdr", mdr_out, 16'h4321);
    tick();
`endif

    // Reset in the 2nd ACCESS cycle aborts the access
    load(16'h6000, 16'h1111, 1'b1);
    start(1'b1, 1'b1);
    tick();
    chk("abort pre we", 16'(mem_we), 16'h3);
    rst_n = 1'b0;
    #1;
    chk("abort mem_en", 16'(mem_en), 16'h0);
    chk("abort mem_we", 16'(mem_we), 16'h0);
    chk("abort mar", mem_addr, 16'h0);
    chk("abort mdr", mdr_out, 16'h0);
    chk("abort r", 16'(r), 16'h0);
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort post r", 16'(r), 16'h0);
    chk("abort post en", 16'(mem_en), 16'h0);
    mem_ready = 1'b0;
    tick();
    chk("abort post r2", 16'(r), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
